// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the EX-stage divide sequencer.
package cpu_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
    localparam int DIV_ITER = 32;
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration on {rem, quot}.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] quot_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] rem_o,
    output logic [DATA_W-1:0] quot_o
);
    logic [DATA_W:0]   sh;
    logic [DATA_W-1:0] diff;
    logic              ge;
    // The shifted remainder needs one extra bit for unsigned divisors >= 2^31.
    assign sh     = {rem_i, quot_i[DATA_W-1]};
    assign ge     = sh >= {1'b0, divisor_i};
    assign diff   = sh[DATA_W-1:0] - divisor_i;
    assign rem_o  = ge ? diff : sh[DATA_W-1:0];
    assign quot_o = {quot_i[DATA_W-2:0], ge};
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle DIV/DIVU controller; stalls EX for 33 cycles and
// pulses ready_o with remainder on hi_o and quotient on lo_o.
module div_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    input  logic              cancel_i,
    output logic              stall_o,
    output logic              ready_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    localparam int CNT_W = $clog2(DIV_ITER);
    div_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rem_q, quot_q, dsr_q, hi_q, lo_q;
    logic              negq_q, negr_q;
    logic [DATA_W-1:0] rem_d, quot_d, dvd_abs_d, dsr_abs_d;
    logic              dvd_neg, dsr_neg;
    assign dvd_neg   = signed_i & dividend_i[DATA_W-1];
    assign dsr_neg   = signed_i & divisor_i[DATA_W-1];
    assign dvd_abs_d = dvd_neg ? -dividend_i : dividend_i;
    assign dsr_abs_d = dsr_neg ? -divisor_i : divisor_i;
    div_step #(.DATA_W(DATA_W)) u_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (dsr_q),
        .rem_o     (rem_d),
        .quot_o    (quot_d)
    );
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            dsr_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (cancel_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    if (divisor_i != '0) begin
                        rem_q   <= '0;
                        quot_q  <= dvd_abs_d;
                        dsr_q   <= dsr_abs_d;
                        negq_q  <= dvd_neg ^ dsr_neg;
                        negr_q  <= dvd_neg;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end else begin
                        lo_q    <= DIV0_LO;
                        hi_q    <= dividend_i;
                        state_q <= DONE;
                    end
                end
                BUSY: begin
                    rem_q  <= rem_d;
                    quot_q <= quot_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
                        lo_q    <= negq_q ? -quot_d : quot_d;
                        hi_q    <= negr_q ? -rem_d : rem_d;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign stall_o = !rst_i && !cancel_i && ((state_q == IDLE && start_i) || state_q == BUSY);
    assign ready_o = state_q == DONE && !cancel_i;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed vectors with hand-computed results for div_sequencer.
module tb_div_sequencer;
    logic        clk_i, rst_i, start_i, signed_i, cancel_i;
    logic [31:0] dividend_i, divisor_i;
    logic        stall_o, ready_o;
    logic [31:0] hi_o, lo_o;
    int total = 0, bad = 0, cyc = 0;

    div_sequencer #(.DATA_W(32)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .cancel_i   (cancel_i),
        .stall_o    (stall_o),
        .ready_o    (ready_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_rdy(input string tag, output int t);
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!ready_o && n < 100);
        chk({tag, "_rdy"}, 32'(ready_o), 1);
        t = cyc;
    endtask

    task automatic do_div(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] elo, input logic [31:0] ehi, input int est);
        int st, n;
        bit got;
        st = 0; n = 0; got = 0;
        @(posedge clk_i); #1;
        start_i = 1; signed_i = s; dividend_i = a; divisor_i = b;
        while (!got && n < 100) begin
            @(negedge clk_i);
            n++;
            if (ready_o) got = 1;
            else if (stall_o) st++;
        end
        chk({tag, "_rdy"}, 32'(got), 1);
        chk({tag, "_stall_done"}, 32'(stall_o), 0);
        chk({tag, "_stall_n"}, st, est);
        chk({tag, "_lo"}, lo_o, elo);
        chk({tag, "_hi"}, hi_o, ehi);
        @(posedge clk_i); #1;
        start_i = 0;
        @(negedge clk_i);
        chk({tag, "_pulse"}, 32'(ready_o), 0);
    endtask

    initial begin
        int t1, t2, hits;
        rst_i = 1; start_i = 1; signed_i = 0; cancel_i = 0;
        dividend_i = 100; divisor_i = 7;
        #2;
        chk("rst_stall", 32'(stall_o), 0);
        chk("rst_ready", 32'(ready_o), 0);
        chk("rst_hi", hi_o, 0);
        chk("rst_lo", lo_o, 0);
        @(posedge clk_i); #1;
        rst_i = 0; start_i = 0;

        do_div("divu_100_7", 0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        do_div("div_m7_2", 1, -32'sd7, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        do_div("div_min_m1", 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
        do_div("divu_5_0", 0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1);
        do_div("div_m8_0", 1, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 1);
        do_div("divu_big_10", 0, 32'hFFFF_FFFF, 32'd10, 32'h1999_9999, 32'd5, 33);
        do_div("divu_big_big", 0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 33);
        do_div("divu_min_max", 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
        do_div("div_7_m2", 1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);

        // start and cancel together in IDLE must not launch a divide
        @(posedge clk_i); #1;
        start_i = 1; cancel_i = 1; signed_i = 0; dividend_i = 9; divisor_i = 3;
        @(negedge clk_i);
        chk("idle_cancel_stall", 32'(stall_o), 0);
        @(posedge clk_i); #1;
        start_i = 0; cancel_i = 0;
        @(negedge clk_i);
        chk("idle_cancel_busy", 32'(stall_o), 0);
        chk("idle_cancel_ready", 32'(ready_o), 0);

        // cancel in BUSY cycle 10
        @(posedge clk_i); #1;
        start_i = 1; signed_i = 1; dividend_i = 100; divisor_i = 7;
        repeat (10) @(posedge clk_i);
        #1 cancel_i = 1;
        @(negedge clk_i);
        chk("cancel_stall", 32'(stall_o), 0);
        chk("cancel_ready", 32'(ready_o), 0);
        @(posedge clk_i); #1;
        cancel_i = 0; start_i = 0;
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (ready_o || stall_o) hits++;
        end
        chk("cancel_quiet", hits, 0);
        chk("cancel_lo_kept", lo_o, 32'hFFFF_FFFD);
        chk("cancel_hi_kept", hi_o, 32'd1);

        // back-to-back DIVUs with start held through DONE
        @(posedge clk_i); #1;
        start_i = 1; signed_i = 0; dividend_i = 9; divisor_i = 3;
        wait_rdy("b2b_1", t1);
        chk("b2b_1_lo", lo_o, 32'd3);
        chk("b2b_1_hi", hi_o, 32'd0);
        @(posedge clk_i); #1;
        dividend_i = 10; divisor_i = 4;
        @(negedge clk_i);
        chk("b2b_restall", 32'(stall_o), 1);
        wait_rdy("b2b_2", t2);
        chk("b2b_2_lo", lo_o, 32'd2);
        chk("b2b_2_hi", hi_o, 32'd2);
        chk("b2b_gap", t2 - t1, 34);
        @(posedge clk_i); #1;
        start_i = 0;

        // asynchronous reset in BUSY cycle 5 of a third divide
        @(posedge clk_i); #1;
        start_i = 1; dividend_i = 100; divisor_i = 7;
        repeat (5) @(posedge clk_i);
        #2 rst_i = 1;
        #1;
        chk("arst_stall", 32'(stall_o), 0);
        chk("arst_ready", 32'(ready_o), 0);
        chk("arst_hi", hi_o, 0);
        chk("arst_lo", lo_o, 0);
        start_i = 0;
        @(posedge clk_i); #1;
        rst_i = 0;
        @(negedge clk_i);
        chk("arst_idle", 32'(stall_o | ready_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
